// File: rtl/instr_inj_pkg.sv
// Shared types and default parameter values for the instruction injector.
package instr_inj_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_GAP_CYC   = 4;

endpackage

// File: rtl/instr_inj_timer.sv
// Down-counter for PULSE/GAP phase lengths; expired is high while the count sits at zero.
module instr_inj_timer #(
  parameter int CNT_W = 2
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/instr_injector.sv
// Program buffer plus issue FSM that feeds words to a CPU with timed _newinstr pulses.
// Build option: define INSTR_INJ_LOOP_EN to add the _loop input (repeat the program until stopped).
//
// state | meaning
// IDLE  | buffer may be loaded/cleared; waits for _start
// PULSE | _newinstr high, current word presented
// GAP   | _newinstr low, current word held
// DONE  | one-cycle _done pulse, then IDLE
module instr_injector
  import instr_inj_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
)(
  input  logic                       _clock,
  input  logic                       _reset,
  input  logic [WORD_W-1:0]          _wrword,
  input  logic                       _wren,
  input  logic                       _clear,
  input  logic                       _start,
  input  logic                       _stop,
`ifdef INSTR_INJ_LOOP_EN
  input  logic                       _loop,
`endif
  output logic [WORD_W-1:0]          _instrword,
  output logic                       _newinstr,
  output logic [$clog2(DEPTH):0]     _len,
  output logic                       _full,
  output logic                       _busy,
  output logic                       _done
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int LEN_W   = IDX_W + 1;
  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic [LEN_W-1:0]  len;
  logic [WORD_W-1:0] mem [DEPTH];
  logic              full;
  logic              last;
  logic              loop_on;
  logic              more;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_exp;

`ifdef INSTR_INJ_LOOP_EN
  assign loop_on = _loop;
`else
  assign loop_on = 1'b0;
`endif

  assign full    = (len == LEN_W'(DEPTH));
  assign last    = ((LEN_W'(idx) + LEN_W'(1)) == len);
  assign more    = !last || loop_on;
  assign nxt_idx = last ? '0 : idx + IDX_W'(1);
  assign _len    = len;
  assign _full   = full;

  // Storage is deliberately left unreset; only len decides what is valid.
  always_ff @(posedge _clock) begin
    if (!_reset && state == IDLE && _wren && !_clear && !full) begin
      mem[len[IDX_W-1:0]] <= _wrword;
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PULSE_LD;
    case (state)
      IDLE:  tmr_load = _start && (len != '0);
      PULSE: begin
        tmr_load = !_stop && tmr_exp;
        tmr_val  = GAP_LD;
      end
      GAP:   tmr_load = !_stop && tmr_exp && more;
      default: tmr_load = 1'b0;
    endcase
  end

  instr_inj_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (_clock),
    .rst      (_reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state      <= IDLE;
      len        <= '0;
      idx        <= '0;
      _instrword <= '0;
      _newinstr  <= 1'b0;
      _busy      <= 1'b0;
      _done      <= 1'b0;
    end else begin
      _done <= 1'b0;
      case (state)
        IDLE: begin
          if (_clear) begin
            len <= '0;
          end else if (_wren && !full) begin
            len <= len + LEN_W'(1);
          end
          if (_start) begin
            idx <= '0;
            if (len != '0) begin
              state      <= PULSE;
              _newinstr  <= 1'b1;
              _busy      <= 1'b1;
              _instrword <= mem[IDX_W'(0)];
            end else begin
              state <= DONE;
              _done <= 1'b1;
            end
          end
        end
        PULSE: begin
          if (_stop) begin
            state     <= IDLE;
            _newinstr <= 1'b0;
            _busy     <= 1'b0;
          end else if (tmr_exp) begin
            state     <= GAP;
            _newinstr <= 1'b0;
          end
        end
        GAP: begin
          if (_stop) begin
            state <= IDLE;
            _busy <= 1'b0;
          end else if (tmr_exp) begin
            if (more) begin
              state      <= PULSE;
              idx        <= nxt_idx;
              _newinstr  <= 1'b1;
              _instrword <= mem[nxt_idx];
            end else begin
              state <= DONE;
              _busy <= 1'b0;
              _done <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_injector.sv
// Randomized self-checking bench for instr_injector; expected traces come from cycle arithmetic.
module tb_instr_injector;

  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int P     = 2;
  localparam int G     = 4;
  localparam int PER   = P + G;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  wrword = '0;
  logic          wren = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
`ifdef INSTR_INJ_LOOP_EN
  logic          loop = 1'b0;
`endif
  logic [W-1:0]  instrword;
  logic          newinstr;
  logic [3:0]    len;
  logic          full;
  logic          busy;
  logic          done;

  logic [W-1:0]  model_buf[$];
  logic [W-1:0]  last_word = '0;
  int            pass_cnt = 0;
  int            check_cnt = 0;

  always #5 clk = ~clk;

  instr_injector #(.WORD_W(W), .DEPTH(DEPTH), .PULSE_CYC(P), .GAP_CYC(G)) dut (
    ._clock    (clk),
    ._reset    (rst),
    ._wrword   (wrword),
    ._wren     (wren),
    ._clear    (clear),
    ._start    (start),
    ._stop     (stop),
`ifdef INSTR_INJ_LOOP_EN
    ._loop     (loop),
`endif
    ._instrword(instrword),
    ._newinstr (newinstr),
    ._len      (len),
    ._full     (full),
    ._busy     (busy),
    ._done     (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Append with the buffer's own rule: accepted only while not full.
  task automatic load_word(input logic [W-1:0] w);
    wrword = w;
    wren   = 1'b1;
    tick();
    wren   = 1'b0;
    if (model_buf.size() < DEPTH) model_buf.push_back(w);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_buf.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_cnt++;
    if ({busy, newinstr, done, full, len, instrword} !== 40'h0)
      $display("FAIL reset_state got=%h exp=0", {busy, newinstr, done, full, len, instrword});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({busy, done, len} !== 6'h0) $display("FAIL reset_idle got=%h exp=0", {busy, done, len});
    else pass_cnt++;
  endtask

  task automatic test_issue();
    logic [W-1:0] fixed3 [3] = '{32'h8C010000, 32'h8C020001, 32'h8C030002};
    for (int r = 0; r < 5; r++) begin
      int n;
      if (r == 0) begin
        do_clear();
        for (int i = 0; i < 3; i++) load_word(fixed3[i]);
      end else if (r != 2) begin
        do_clear();
        n = $urandom_range(1, DEPTH);
        for (int i = 0; i < n; i++) load_word($urandom);
      end
      n = model_buf.size();
      check_cnt++;
      if (len !== 4'(n)) $display("FAIL issue_len r=%0d got=%0d exp=%0d", r, len, n);
      else pass_cnt++;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= n * PER + 2; k++) begin
        logic [W+2:0] exp_v;
        if (k <= n * PER)
          exp_v = {1'b1, ((k - 1) % PER) < P, 1'b0, model_buf[(k - 1) / PER]};
        else
          exp_v = {1'b0, 1'b0, k == n * PER + 1, model_buf[n - 1]};
        check_cnt++;
        if ({busy, newinstr, done, instrword} !== exp_v)
          $display("FAIL issue_trace r=%0d k=%0d got=%h exp=%h", r, k, {busy, newinstr, done, instrword}, exp_v);
        else pass_cnt++;
        // Writes and starts while not idle must be ignored.
        if (k <= n * PER + 1) begin
          wren   = 1'($urandom_range(0, 1));
          wrword = $urandom;
          start  = ($urandom_range(0, 3) == 0);
        end else begin
          wren  = 1'b0;
          start = 1'b0;
        end
        tick();
      end
      wren  = 1'b0;
      start = 1'b0;
      last_word = model_buf[n - 1];
      check_cnt++;
      if (len !== 4'(n)) $display("FAIL issue_len_kept r=%0d got=%0d exp=%0d", r, len, n);
      else pass_cnt++;
    end
  endtask

  task automatic test_full();
    logic [W-1:0] w9 = 32'hFFFF_FFFF;
    int pulses = 0;
    bit saw9 = 0;
    bit got_done = 0;
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_word($urandom & 32'h7FFF_FFFF);
    load_word(w9);
    check_cnt++;
    if (full !== 1'b1) $display("FAIL full_flag got=%b exp=1", full);
    else pass_cnt++;
    check_cnt++;
    if (len !== 4'd8) $display("FAIL full_len got=%0d exp=8", len);
    else pass_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < DEPTH * PER + 5; i++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (newinstr) pulses++;
      if (instrword == w9) saw9 = 1;
      tick();
    end
    check_cnt++;
    if (!got_done) $display("FAIL full_done_timeout got=0 exp=1");
    else pass_cnt++;
    check_cnt++;
    if (pulses != DEPTH * P) $display("FAIL full_pulse_cycles got=%0d exp=%0d", pulses, DEPTH * P);
    else pass_cnt++;
    check_cnt++;
    if (saw9) $display("FAIL full_9th_issued got=1 exp=0");
    else pass_cnt++;
    check_cnt++;
    if (instrword !== model_buf[DEPTH - 1]) $display("FAIL full_last_word got=%h exp=%h", instrword, model_buf[DEPTH - 1]);
    else pass_cnt++;
    tick();
    last_word = model_buf[DEPTH - 1];
  endtask

  task automatic test_stop();
    int i;
    do_clear();
    load_word(32'h8C010000);
    load_word(32'h8C020001);
    load_word(32'h8C030002);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2 * PER - 1) tick();
    // Last cycle of the 2nd gap: stop must win over the timer expiring.
    check_cnt++;
    if ({busy, newinstr, instrword} !== {2'b10, 32'h8C020001})
      $display("FAIL stop_in_gap got=%h exp=%h", {busy, newinstr, instrword}, {2'b10, 32'h8C020001});
    else pass_cnt++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_cnt++;
    if ({busy, newinstr, done} !== 3'b000) $display("FAIL stop_idle got=%b exp=000", {busy, newinstr, done});
    else pass_cnt++;
    for (int j = 0; j < 4; j++) begin
      tick();
      check_cnt++;
      if ({newinstr, done} !== 2'b00) $display("FAIL stop_quiet j=%0d got=%b exp=00", j, {newinstr, done});
      else pass_cnt++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check_cnt++;
    if ({newinstr, instrword} !== {1'b1, 32'h8C010000})
      $display("FAIL stop_reissue got=%h exp=%h", {newinstr, instrword}, {1'b1, 32'h8C010000});
    else pass_cnt++;
    for (i = 0; i < 3 * PER + 4; i++) begin
      if (done) break;
      tick();
    end
    check_cnt++;
    if (i != 3 * PER) $display("FAIL stop_reissue_done got=%0d exp=%0d", i, 3 * PER);
    else pass_cnt++;
    tick();
    last_word = 32'h8C030002;
  endtask

  task automatic test_empty();
    do_clear();
    check_cnt++;
    if (len !== 4'd0) $display("FAIL empty_len got=%0d exp=0", len);
    else pass_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_cnt++;
    if ({busy, newinstr, done, instrword} !== {3'b001, last_word})
      $display("FAIL empty_done got=%h exp=%h", {busy, newinstr, done, instrword}, {3'b001, last_word});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({newinstr, done} !== 2'b00) $display("FAIL empty_after got=%b exp=00", {newinstr, done});
    else pass_cnt++;
  endtask

  task automatic test_clear_write();
    do_clear();
    load_word($urandom);
    load_word($urandom);
    check_cnt++;
    if (len !== 4'd2) $display("FAIL clr_pre_len got=%0d exp=2", len);
    else pass_cnt++;
    clear  = 1'b1;
    wren   = 1'b1;
    wrword = $urandom;
    tick();
    clear = 1'b0;
    wren  = 1'b0;
    model_buf.delete();
    check_cnt++;
    if (len !== 4'd0) $display("FAIL clr_with_wren got=%0d exp=0", len);
    else pass_cnt++;
    load_word($urandom);
    check_cnt++;
    if ({full, len} !== 5'b0_0001) $display("FAIL clr_then_write got=%b exp=00001", {full, len});
    else pass_cnt++;
  endtask

`ifdef INSTR_INJ_LOOP_EN
  task automatic test_loop();
    do_clear();
    load_word(32'h00221820);
    load_word(32'h00A32022);
    loop  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 3 * 2 * PER + 1; k++) begin
      logic [W+2:0] exp_v;
      exp_v = {1'b1, ((k - 1) % PER) < P, 1'b0, model_buf[((k - 1) / PER) % 2]};
      check_cnt++;
      if ({busy, newinstr, done, instrword} !== exp_v)
        $display("FAIL loop_trace k=%0d got=%h exp=%h", k, {busy, newinstr, done, instrword}, exp_v);
      else pass_cnt++;
      if (k <= 3 * 2 * PER) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    loop = 1'b0;
    check_cnt++;
    if ({busy, newinstr, done} !== 3'b000) $display("FAIL loop_stop got=%b exp=000", {busy, newinstr, done});
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done !== 1'b0) $display("FAIL loop_no_done got=%b exp=0", done);
    else pass_cnt++;
    last_word = model_buf[0];
  endtask
`endif

  task automatic test_reset_mid();
    do_clear();
    for (int i = 0; i < DEPTH; i++) load_word($urandom);
    check_cnt++;
    if (full !== 1'b1) $display("FAIL rmid_full got=%b exp=1", full);
    else pass_cnt++;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (PER) tick();
    check_cnt++;
    if ({newinstr, instrword} !== {1'b1, model_buf[1]})
      $display("FAIL rmid_word2 got=%h exp=%h", {newinstr, instrword}, {1'b1, model_buf[1]});
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_buf.delete();
    last_word = '0;
    check_cnt++;
    if ({newinstr, instrword, len, busy, done, full} !== 40'h0)
      $display("FAIL rmid_cleared got=%h exp=0", {newinstr, instrword, len, busy, done, full});
    else pass_cnt++;
    tick();
    check_cnt++;
    if ({busy, newinstr, done} !== 3'b000) $display("FAIL rmid_stays_idle got=%b exp=000", {busy, newinstr, done});
    else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_issue();
    test_full();
    test_stop();
    test_empty();
    test_clear_write();
`ifdef INSTR_INJ_LOOP_EN
    test_loop();
`endif
    test_reset_mid();
    test_empty();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
